// File: rtl/display_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// display_pkg
// Shared FSM states and 7-segment encodings for the reg_out display path.
// Revision: 1.0
//------------------------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low {g,f,e,d,c,b,a}, indexed by decimal digit 9..0
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

endpackage
`default_nettype wire

// File: rtl/reg_out_display_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// reg_out_display_if
// Bus between the CPU reg_out producer and the HEX display consumer.
// Revision: 1.0
//------------------------------------------------------------------------------
interface reg_out_display_if #(
   parameter int IN_W = 64
);
   logic [IN_W-1:0] value;
   logic [6:0]      hex0;
   logic [6:0]      hex1;
   logic [6:0]      hex2;
   logic [6:0]      hex3;
   logic            busy;
   logic            overflow;

   modport master (
      output value,
      input  hex0, hex1, hex2, hex3, busy, overflow
   );

   modport slave (
      input  value,
      output hex0, hex1, hex2, hex3, busy, overflow
   );
endinterface
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
//------------------------------------------------------------------------------
// bcd_to_seg7
// One BCD digit to an active-low 7-segment pattern; non-decimal codes blank.
// Revision: 1.0
//------------------------------------------------------------------------------
module bcd_to_seg7
   import display_pkg::*;
(
   input  wire logic [3:0] digit,
   output logic      [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (digit <= 4'd9) begin
         seg = SEG_TABLE[digit];
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_out_display.sv
`default_nettype none
//------------------------------------------------------------------------------
// reg_out_display
// Iterative double-dabble of the CPU reg_out value onto four HEX displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of hex3..hex1.
// Revision: 1.0
//------------------------------------------------------------------------------
module reg_out_display
   import display_pkg::*;
#(
   parameter int IN_W       = 64,
   parameter int DIGITS     = 4,
   parameter int SHIFT_BITS = 14,
   parameter int MAX_VAL    = 9999
) (
   input  wire logic            clk,
   input  wire logic            rst,
   reg_out_display_if.slave     bus
);

   localparam logic [IN_W-1:0] C_MAX = IN_W'(MAX_VAL);
   localparam logic [3:0]      C_LAST_SHIFT = 4'(SHIFT_BITS - 1);

   state_t                      r_state;
   state_t                      w_next_state;
   logic [IN_W-1:0]             r_snap;
   logic                        r_valid;
   logic [SHIFT_BITS-1:0]       r_sr;
   logic [DIGITS-1:0][3:0]      r_bcd;
   logic [DIGITS-1:0][3:0]      w_bcd_adj;
   logic [3:0]                  r_cnt;
   logic [DIGITS-1:0][6:0]      r_hex;
   logic [DIGITS-1:0][6:0]      w_seg;
   logic [DIGITS-1:0][6:0]      w_hex_final;
   logic                        r_overflow;
   logic                        w_capture;
   logic                        w_over;

   assign w_capture = !r_valid || (bus.value != r_snap);
   assign w_over    = bus.value > C_MAX;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_capture && !w_over) w_next_state = SHIFT;
         SHIFT:   if (r_cnt == C_LAST_SHIFT) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         w_bcd_adj[i] = (r_bcd[i] >= 4'd5) ? r_bcd[i] + 4'd3 : r_bcd[i];
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
         bcd_to_seg7 u_seg (
            .digit (r_bcd[gi]),
            .seg   (w_seg[gi])
         );
      end
   endgenerate

   // Walk down from the top digit; once a non-zero digit is seen, stop blanking
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic w_lead;
      w_hex_final = w_seg;
      w_lead      = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_lead = w_lead && (r_bcd[i] == 4'd0);
         if (w_lead) begin
            w_hex_final[i] = SEG_BLANK;
         end
      end
`else
      w_hex_final = w_seg;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_snap     <= '0;
         r_valid    <= 1'b0;
         r_sr       <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_hex      <= {DIGITS{SEG_BLANK}};
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_capture) begin
                  r_snap  <= bus.value;
                  r_valid <= 1'b1;
                  if (w_over) begin
                     r_overflow <= 1'b1;
                     r_hex      <= {DIGITS{SEG_DASH}};
                  end else begin
                     r_sr  <= bus.value[SHIFT_BITS-1:0];
                     r_bcd <= '0;
                     r_cnt <= '0;
                  end
               end
            end
            SHIFT: begin
               {r_bcd, r_sr} <= {w_bcd_adj, r_sr} << 1;
               r_cnt         <= r_cnt + 4'd1;
            end
            DONE: begin
               r_hex      <= w_hex_final;
               r_overflow <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy     = (r_state != IDLE);
      bus.overflow = r_overflow;
      bus.hex0     = r_hex[0];
      bus.hex1     = r_hex[1];
      bus.hex2     = r_hex[2];
      bus.hex3     = r_hex[3];
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_out_display.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_reg_out_display
// Directed vector bench for reg_out_display.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_reg_out_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, BL = 7'h7F,      DS = 7'b0111111;

   typedef struct {
      logic [63:0] v;
      logic [27:0] hex;
      bit          ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   reg_out_display_if #(.IN_W(64)) bus ();

   reg_out_display dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] cur_hex();
      return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
   endfunction

   function automatic logic [27:0] lz(input logic [27:0] h);
      logic [27:0] r;
      r = h;
`ifdef LEADING_ZERO_BLANK_EN
      if (r[27:21] == S0) begin
         r[27:21] = BL;
         if (r[20:14] == S0) begin
            r[20:14] = BL;
            if (r[13:7] == S0) r[13:7] = BL;
         end
      end
`endif
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Value applied just after an edge; the next edge captures, result appears 15 edges later
   task automatic run_normal(input logic [63:0] v, input logic [27:0] exp, input string nm);
      logic [27:0] prev;
      int          busy_n;
      bit          held;
      prev      = cur_hex();
      bus.value = v;
      busy_n    = 0;
      held      = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         if (bus.busy) busy_n++;
         if (cur_hex() !== prev) held = 1'b0;
      end
      @(posedge clk); #1;
      check({nm, " busy_cycles"}, 64'(busy_n), 64'd15);
      check({nm, " held"}, {63'd0, held}, 64'd1);
      check({nm, " hex"}, {36'd0, cur_hex()}, {36'd0, lz(exp)});
      check({nm, " busy_end"}, {63'd0, bus.busy}, 64'd0);
      check({nm, " ovf"}, {63'd0, bus.overflow}, 64'd0);
   endtask

   task automatic run_ovf(input logic [63:0] v, input string nm);
      bit busy_seen;
      bus.value = v;
      @(posedge clk); #1;
      check({nm, " hex"}, {36'd0, cur_hex()}, {36'd0, DS, DS, DS, DS});
      check({nm, " ovf"}, {63'd0, bus.overflow}, 64'd1);
      busy_seen = bus.busy;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (bus.busy) busy_seen = 1'b1;
      end
      check({nm, " no_busy"}, {63'd0, busy_seen}, 64'd0);
      check({nm, " ovf_hold"}, {63'd0, bus.overflow}, 64'd1);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{v: 64'd1234,  hex: {S1, S2, S3, S4}, ovf: 1'b0};
      vecs[1] = '{v: 64'd9999,  hex: {S9, S9, S9, S9}, ovf: 1'b0};
      vecs[2] = '{v: 64'd10000, hex: {DS, DS, DS, DS}, ovf: 1'b1};
      vecs[3] = '{v: 64'hFFFF_FFFF_FFFF_FFFF, hex: {DS, DS, DS, DS}, ovf: 1'b1};
      vecs[4] = '{v: 64'd42,    hex: {S0, S0, S4, S2}, ovf: 1'b0};
      vecs[5] = '{v: 64'd8000,  hex: {S8, S0, S0, S0}, ovf: 1'b0};
      vecs[6] = '{v: 64'd7,     hex: {S0, S0, S0, S7}, ovf: 1'b0};

      bus.value = 64'd0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset hex", {36'd0, cur_hex()}, {36'd0, BL, BL, BL, BL});
      check("reset busy", {63'd0, bus.busy}, 64'd0);
      check("reset ovf", {63'd0, bus.overflow}, 64'd0);
      rst = 1'b1;
      run_normal(64'd0, {S0, S0, S0, S0}, "zero");

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].ovf) run_ovf(vecs[i].v, $sformatf("vec%0d", i));
         else run_normal(vecs[i].v, vecs[i].hex, $sformatf("vec%0d", i));
      end

      // Equal successive value: no recapture
      begin
         bit busy_seen;
         busy_seen = 1'b0;
         for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_seen = 1'b1;
         end
         check("equal no_busy", {63'd0, busy_seen}, 64'd0);
      end

      // Value changes mid-conversion: 5 finishes first, then 6765 follows
      begin
         logic [27:0] prev;
         bit held;
         prev = cur_hex();
         held = 1'b1;
         bus.value = 64'd5;
         for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #1;
            if (n == 3) bus.value = 64'd6765;
            if (cur_hex() !== prev) held = 1'b0;
         end
         @(posedge clk); #1;
         check("five held", {63'd0, held}, 64'd1);
         check("five hex", {36'd0, cur_hex()}, {36'd0, lz({S0, S0, S0, S5})});
         run_normal(64'd6765, {S6, S7, S6, S5}, "fib6765");
      end

      // Async reset in the middle of a conversion
      bus.value = 64'd4181;
      for (int n = 1; n <= 7; n++) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b0;
      #1;
      check("midrst hex", {36'd0, cur_hex()}, {36'd0, BL, BL, BL, BL});
      check("midrst busy", {63'd0, bus.busy}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_normal(64'd4181, {S4, S1, S8, S1}, "fib4181");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
